// File: rtl/affinex_fifo_pkg.sv
// Shared types and helpers for the peripheral FIFO read-side packer.
// Defaults match the 16-bit FIFO feeding the 32-bit data-read path.
package affinex_fifo_pkg;

  localparam int IN_WIDTH_DEF = 16;
  localparam int PACK_DEF     = 2;

  typedef logic [$clog2(PACK_DEF)-1:0] lane_t;

  typedef logic [PACK_DEF-1:0][IN_WIDTH_DEF-1:0] pack_word_t;

  typedef enum logic {
    FL_IDLE,
    FL_WAIT
  } flush_st_e;

  function automatic int unsigned lane_index(
    input int unsigned lane,
    input bit          lsb_first,
    input int unsigned pack = PACK_DEF
  );
    return lsb_first ? lane : (pack - 1 - lane);
  endfunction

endpackage

// File: rtl/fifo_pack_reader.sv
// Pops FIFO entries, packs PACK of them into one word and streams it out.
// flush_i emits a zero-padded partial word, or just acknowledges if empty.
module fifo_pack_reader
  import affinex_fifo_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int PACK      = PACK_DEF,
  parameter int LSB_FIRST = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       fifo_empty_i,
  input  logic [IN_WIDTH-1:0]        fifo_dout_i,
  output logic                       fifo_rd_en_o,
  input  logic                       flush_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [IN_WIDTH*PACK-1:0]   m_data_o,
  output logic [$clog2(PACK+1)-1:0]  m_lanes_o,
  output logic                       flush_done_o
);

  localparam int LW = $clog2(PACK);
  localparam int CW = $clog2(PACK+1);

  typedef logic [PACK-1:0][IN_WIDTH-1:0] word_t;

  flush_st_e       state_q, state_d;
  word_t           acc_q, acc_d;
  word_t           fill;
  word_t           load_data;
  logic [LW-1:0]   lane_q, lane_d;
  logic [LW-1:0]   wr_idx;
  logic [CW-1:0]   load_lanes;
  logic            load;
  logic            out_free;
  logic            at_last;
  logic            retire;

  word_t           out_q;
  logic [CW-1:0]   lanes_q;
  logic            valid_q;

  assign m_valid_o = valid_q;
  assign m_data_o  = out_q;
  assign m_lanes_o = lanes_q;

  always_comb begin
    out_free   = !valid_q | m_ready_i;
    at_last    = lane_q == LW'(PACK-1);
    wr_idx     = LW'(lane_index(32'(lane_q), LSB_FIRST != 0, PACK));
    fill       = acc_q;
    fill[wr_idx] = fifo_dout_i;

    fifo_rd_en_o = !fifo_empty_i & (state_q == FL_IDLE) & !flush_i
                 & !(at_last & !out_free);
    retire       = (state_q == FL_WAIT) & ((lane_q == '0) | out_free);
    flush_done_o = retire;

    state_d    = state_q;
    acc_d      = acc_q;
    lane_d     = lane_q;
    load       = 1'b0;
    load_data  = '0;
    load_lanes = '0;

    unique case (state_q)
      FL_IDLE: begin
        if (flush_i) state_d = FL_WAIT;
      end
      FL_WAIT: begin
        if (retire) begin
          state_d = FL_IDLE;
          acc_d   = '0;
          lane_d  = '0;
          // An empty accumulator retires without emitting a word.
          if (lane_q != '0) begin
            load       = 1'b1;
            load_data  = acc_q;
            load_lanes = CW'(lane_q);
          end
        end
      end
    endcase

    if (fifo_rd_en_o) begin
      if (at_last) begin
        load       = 1'b1;
        load_data  = fill;
        load_lanes = CW'(PACK);
        acc_d      = '0;
        lane_d     = '0;
      end else begin
        acc_d  = fill;
        lane_d = lane_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FL_IDLE;
      acc_q   <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lane_q  <= lane_d;
    end
  end

  // Reload and drain may coincide, giving back-to-back words.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q   <= '0;
      lanes_q <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      out_q   <= load_data;
      lanes_q <= load_lanes;
      valid_q <= 1'b1;
    end else if (valid_q & m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Directed vector table plus corner sequences and a random scoreboard run.
// A small 4-deep FIFO model feeds the main instance.
module tb_fifo_pack_reader;
  import affinex_fifo_pkg::*;

  localparam int W  = 16;
  localparam int P  = 2;
  localparam int CW = $clog2(P+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic [W-1:0]   mem [4];
  logic [1:0]     rp, wp;
  int             cnt;

  logic           empty, rd_en, flush, ready, valid, done;
  logic [W-1:0]   dout;
  logic [W*P-1:0] data;
  logic [CW-1:0]  lanes;

  logic           empty2, rd2, flush2, ready2, valid2, done2;
  logic [W-1:0]   dout2;
  logic [W*P-1:0] data2;
  logic [CW-1:0]  lanes2;

  int total = 0;
  int passed = 0;

  assign empty = (cnt == 0);
  assign dout  = mem[rp];

  always @(posedge clk) begin
    if (rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= 0;
    end else begin
      if (wr_en && cnt < 4) begin
        mem[wp] <= wr_data;
        wp <= wp + 2'd1;
      end
      if (rd_en && !empty) rp <= rp + 2'd1;
      cnt <= cnt + ((wr_en && cnt < 4) ? 1 : 0)
                 - ((rd_en && !empty) ? 1 : 0);
    end
  end

  fifo_pack_reader #(.IN_WIDTH(W), .PACK(P), .LSB_FIRST(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .fifo_empty_i(empty), .fifo_dout_i(dout), .fifo_rd_en_o(rd_en),
    .flush_i(flush),
    .m_valid_o(valid), .m_ready_i(ready),
    .m_data_o(data), .m_lanes_o(lanes),
    .flush_done_o(done)
  );

  fifo_pack_reader #(.IN_WIDTH(W), .PACK(P), .LSB_FIRST(0)) u_msb (
    .clk_i(clk), .rst_i(rst),
    .fifo_empty_i(empty2), .fifo_dout_i(dout2), .fifo_rd_en_o(rd2),
    .flush_i(flush2),
    .m_valid_o(valid2), .m_ready_i(ready2),
    .m_data_o(data2), .m_lanes_o(lanes2),
    .flush_done_o(done2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w, input logic [W-1:0] wd,
                       input bit r, input bit f);
    wr_en   = w;
    wr_data = wd;
    ready   = r;
    flush   = f;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] wd;
    bit          rdy;
    bit          fl;
    bit          e_rd;
    bit          e_done;
    bit          e_val;
    bit          chk_d;
    logic [31:0] e_data;
    logic [1:0]  e_lanes;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [15:0] wd, bit rdy, bit fl,
                              bit erd, bit edn, bit ev, bit cd,
                              logic [31:0] ed, logic [1:0] el);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rdy = rdy; v.fl = fl;
    v.e_rd = erd; v.e_done = edn; v.e_val = ev; v.chk_d = cd;
    v.e_data = ed; v.e_lanes = el;
    return v;
  endfunction

  vec_t vt [27];
  logic [W-1:0] sb [$];
  int n_ovl;
  int n_words;

  initial begin
    vt[0]  = mk(1, 16'h1111, 1, 0, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[1]  = mk(1, 16'h2222, 1, 0, 1, 0, 0, 0, 32'h0, 2'd0);
    vt[2]  = mk(0, 16'h0,    1, 0, 1, 0, 1, 1, 32'h2222_1111, 2'd2);
    vt[3]  = mk(0, 16'h0,    1, 0, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[4]  = mk(1, 16'h000A, 0, 0, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[5]  = mk(1, 16'h000B, 0, 0, 1, 0, 0, 0, 32'h0, 2'd0);
    vt[6]  = mk(1, 16'h000C, 0, 0, 1, 0, 1, 1, 32'h000B_000A, 2'd2);
    vt[7]  = mk(1, 16'h000D, 0, 0, 1, 0, 1, 1, 32'h000B_000A, 2'd2);
    vt[8]  = mk(0, 16'h0,    0, 0, 0, 0, 1, 1, 32'h000B_000A, 2'd2);
    vt[9]  = mk(0, 16'h0,    0, 0, 0, 0, 1, 1, 32'h000B_000A, 2'd2);
    vt[10] = mk(0, 16'h0,    1, 0, 1, 0, 1, 1, 32'h000D_000C, 2'd2);
    vt[11] = mk(0, 16'h0,    1, 0, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[12] = mk(1, 16'h3333, 1, 0, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[13] = mk(0, 16'h0,    1, 0, 1, 0, 0, 0, 32'h0, 2'd0);
    vt[14] = mk(0, 16'h0,    1, 1, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[15] = mk(0, 16'h0,    1, 0, 0, 1, 1, 1, 32'h0000_3333, 2'd1);
    vt[16] = mk(0, 16'h0,    1, 0, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[17] = mk(0, 16'h0,    1, 1, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[18] = mk(0, 16'h0,    1, 0, 0, 1, 0, 0, 32'h0, 2'd0);
    vt[19] = mk(0, 16'h0,    1, 0, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[20] = mk(1, 16'h4444, 1, 0, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[21] = mk(0, 16'h0,    1, 1, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[22] = mk(0, 16'h0,    1, 0, 0, 1, 0, 0, 32'h0, 2'd0);
    vt[23] = mk(0, 16'h0,    1, 0, 1, 0, 0, 0, 32'h0, 2'd0);
    vt[24] = mk(1, 16'h5555, 1, 0, 0, 0, 0, 0, 32'h0, 2'd0);
    vt[25] = mk(0, 16'h0,    1, 0, 1, 0, 1, 1, 32'h5555_4444, 2'd2);
    vt[26] = mk(0, 16'h0,    1, 0, 0, 0, 0, 0, 32'h0, 2'd0);

    rst = 1'b1;
    drive(0, '0, 0, 0);
    empty2 = 1'b1; dout2 = '0; flush2 = 1'b0; ready2 = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_data", data, 32'h0);
    chk("rst_lanes", 32'(lanes), 32'h0);
    chk("rst_rd_en", 32'(rd_en), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      drive(vt[i].wr, vt[i].wd, vt[i].rdy, vt[i].fl);
      #1;
      chk($sformatf("v%0d_rd_en", i), 32'(rd_en), 32'(vt[i].e_rd));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vt[i].e_done));
      tick();
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vt[i].e_val));
      if (vt[i].chk_d) begin
        chk($sformatf("v%0d_data", i), data, vt[i].e_data);
        chk($sformatf("v%0d_lanes", i), 32'(lanes), 32'(vt[i].e_lanes));
      end
    end

    // Reset with a held word and a half-filled accumulator.
    drive(1, 16'h7001, 0, 0); tick();
    drive(1, 16'h7002, 0, 0); tick();
    drive(1, 16'h7003, 0, 0); tick();
    drive(0, '0, 0, 0);       tick();
    chk("pre_rst_valid", 32'(valid), 32'h1);
    chk("pre_rst_data", data, 32'h7002_7001);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_data", data, 32'h0);
    chk("mid_rst_lanes", 32'(lanes), 32'h0);
    chk("mid_rst_rd_en", 32'(rd_en), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    drive(0, '0, 1, 0); tick(); tick();
    chk("post_rst_valid", 32'(valid), 32'h0);
    drive(1, 16'h7004, 1, 0); tick();
    drive(1, 16'h7005, 1, 0); tick();
    drive(0, '0, 1, 0);       tick();
    chk("post_rst_valid2", 32'(valid), 32'h1);
    chk("post_rst_data", data, 32'h7005_7004);
    tick();

    // Random writes and backpressure against an in-order scoreboard.
    n_ovl = 0;
    n_words = 0;
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ($urandom_range(0, 99) < 60) && (cnt < 4);
      wr_data = 16'($urandom);
      ready   = ($urandom_range(0, 99) < 55);
      flush   = 1'b0;
      if (wr_en) sb.push_back(wr_data);
      #1;
      if (rd_en && empty) n_ovl++;
      if (valid && ready) begin
        if (sb.size() >= 2) begin
          chk("rand_word", data, {sb[1], sb[0]});
          void'(sb.pop_front());
          void'(sb.pop_front());
          n_words++;
        end else begin
          chk("rand_underflow", 32'(sb.size()), 32'd2);
        end
      end
      tick();
    end
    chk("rand_rd_while_empty", 32'(n_ovl), 32'h0);
    chk("rand_min_words", 32'(n_words > 200), 32'h1);

    // Reverse lane order on the second instance.
    empty2 = 1'b0; dout2 = 16'h1111; ready2 = 1'b1;
    #1;
    chk("msb_rd_en", 32'(rd2), 32'h1);
    tick();
    dout2 = 16'h2222;
    tick();
    empty2 = 1'b1;
    chk("msb_valid", 32'(valid2), 32'h1);
    chk("msb_data", data2, 32'h1111_2222);
    chk("msb_lanes", 32'(lanes2), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
